// File: rtl/pll_phase_pkg.sv
// Shared types and encodings for the PLL dynamic-phase-shift sequencer.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_STEP_ON   = 3'd2,
    ST_STEP_OFF  = 3'd3,
    ST_LOAD_ON   = 3'd4,
    ST_LOAD_OFF  = 3'd5,
    ST_SETTLE    = 3'd6,
    ST_LOCK_WAIT = 3'd7
  } pll_state_e;

  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;

  localparam logic DIR_DELAY   = 1'b0;
  localparam logic DIR_ADVANCE = 1'b1;

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Command channel from link training into the phase-shift sequencer.
// Valid/ready: master holds CMD_VALID and all CMD_* fields stable until the
// edge where CMD_VALID & CMD_READY are both high; that edge transfers the command.
interface pll_phase_ctrl_if #(
  parameter int STEPS_W = 8
);
  logic               CMD_VALID;
  logic               CMD_READY;
  logic [1:0]         CMD_SEL;
  logic               CMD_DIR;
  logic [STEPS_W-1:0] CMD_STEPS;
  logic               CMD_LOAD;

  modport master (output CMD_VALID, CMD_SEL, CMD_DIR, CMD_STEPS, CMD_LOAD,
                  input  CMD_READY);
  modport slave  (input  CMD_VALID, CMD_SEL, CMD_DIR, CMD_STEPS, CMD_LOAD,
                  output CMD_READY);
endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for PLL status inputs; output resets low.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG for one phase-shift
// command at a time, tracks per-output phase offsets and checks LOCK afterwards.
module pll_phase_ctrl
  import pll_phase_pkg::*;
#(
  parameter int STEPS_W      = 8,
  parameter int PHASE_W      = 10,
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 4,
  parameter int GAP_CYC      = 4,
  parameter int SETTLE_CYC   = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  pll_phase_ctrl_if.slave      cmd,
  input  logic                 LOCK,
  output logic [1:0]           PHASESEL,
  output logic                 PHASEDIR,
  output logic                 PHASESTEP,
  output logic                 PHASELOADREG,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic                 LOCK_OK,
  output logic [4*PHASE_W-1:0] PHASE_OFS,
  output pll_state_e           DBG_STATE
);
  localparam int TMR_MAX = (SETTLE_CYC > LOCK_TIMEOUT) ? SETTLE_CYC : LOCK_TIMEOUT;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] T_SETUP  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] T_PULSE  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] T_GAP    = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCK_TIMEOUT - 1);

  pll_state_e         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [1:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               load_q, load_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               step_q, step_d;
  logic               ldreg_q, ldreg_d;
  logic [PHASE_W-1:0] acc_q [4];
  logic [PHASE_W-1:0] acc_d [4];
  logic               lock_ok;
  logic               accept;
  logic               tmr_zero;

  pll_lock_sync u_lock_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (LOCK),
    .q_o    (lock_ok)
  );

  assign cmd.CMD_READY = (state_q == ST_IDLE) & lock_ok;
  assign accept        = cmd.CMD_VALID & cmd.CMD_READY;
  assign tmr_zero      = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    load_d  = load_q;
    err_d   = err_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_SETUP;
        tmr_d   = T_SETUP;
        sel_d   = cmd.CMD_SEL;
        dir_d   = cmd.CMD_DIR;
        steps_d = cmd.CMD_STEPS;
        load_d  = cmd.CMD_LOAD;
        err_d   = 1'b0;
      end
      ST_SETUP: if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else if (steps_q != '0) begin state_d = ST_STEP_ON; tmr_d = T_PULSE;  end
        else if (load_q)        begin state_d = ST_LOAD_ON; tmr_d = T_PULSE;  end
        else                    begin state_d = ST_SETTLE;  tmr_d = T_SETTLE; end
      // Each step is booked into the offset as its pulse ends.
      ST_STEP_ON: if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else begin
          state_d       = ST_STEP_OFF;
          tmr_d         = T_GAP;
          steps_d       = steps_q - 1'b1;
          acc_d[sel_q]  = (dir_q == DIR_ADVANCE) ? acc_q[sel_q] - 1'b1
                                                 : acc_q[sel_q] + 1'b1;
        end
      ST_STEP_OFF: if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else if (steps_q != '0) begin state_d = ST_STEP_ON; tmr_d = T_PULSE;  end
        else if (load_q)        begin state_d = ST_LOAD_ON; tmr_d = T_PULSE;  end
        else                    begin state_d = ST_SETTLE;  tmr_d = T_SETTLE; end
      ST_LOAD_ON: if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else begin state_d = ST_LOAD_OFF; tmr_d = T_GAP; end
      ST_LOAD_OFF: if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else begin state_d = ST_SETTLE; tmr_d = T_SETTLE; end
      ST_SETTLE: if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else begin state_d = ST_LOCK_WAIT; tmr_d = T_LOCK; end
      ST_LOCK_WAIT: if (lock_ok) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else tmr_d = tmr_q - 1'b1;
      default: state_d = ST_IDLE;
    endcase
    // Pulse outputs come straight from flops so the PLL never sees decode glitches.
    step_d  = (state_d == ST_STEP_ON);
    ldreg_d = (state_d == ST_LOAD_ON);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      steps_q <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
      ldreg_q <= 1'b0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      steps_q <= steps_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      err_q   <= err_d;
      done_q  <= done_d;
      step_q  <= step_d;
      ldreg_q <= ldreg_d;
      acc_q   <= acc_d;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ofs
    assign PHASE_OFS[k*PHASE_W +: PHASE_W] = acc_q[k];
  end

  assign PHASESEL     = sel_q;
  assign PHASEDIR     = dir_q;
  assign PHASESTEP    = step_q;
  assign PHASELOADREG = ldreg_q;
  assign BUSY         = (state_q != ST_IDLE);
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign LOCK_OK      = lock_ok;
  assign DBG_STATE    = state_q;
endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
Sequencer for the dynamic-phase-shift port of the PLL_SerDes EHXPLLL wrapper. It drives PHASESEL, PHASEDIR, PHASESTEP and PHASELOADREG.
- Accepts phase-shift commands over a valid/ready handshake, one at a time.
- Emits N correctly timed step pulses per command.
- Keeps a signed phase-offset record per PLL output.
- Supervises LOCK after each command.
- Sits between the SerDes link-training logic and the PLL_SerDes instance. Clocked from a free-running clock, not a PLL output.

Parameters:
STEPS_W, 8, width of the step-count field.
PHASE_W, 10, width of each signed per-channel offset accumulator.
SETUP_CYC, 4, cycles PHASESEL/PHASEDIR are held stable before the first PHASESTEP pulse.
PULSE_CYC, 4, PHASESTEP / PHASELOADREG active width in cycles (min 1).
GAP_CYC, 4, inactive cycles after each pulse (min 1).
SETTLE_CYC, 64, cycles waited after the last pulse before LOCK is checked.
LOCK_TIMEOUT, 4096, maximum further cycles to wait for LOCK before error.

Ports:
CLK  in  1  controller clock.
RST_N  in  1  asynchronous active-low reset.
CMD_VALID  in  1  command present.
CMD_READY  out  1  controller can accept a command.
CMD_SEL  in  2  target output: 0=CLKOS, 1=CLKOS2, 2=CLKOS3, 3=CLKOP.
CMD_DIR  in  1  0 = delay (+1 per step), 1 = advance (-1 per step).
CMD_STEPS  in  STEPS_W  number of step pulses, 0 allowed.
CMD_LOAD  in  1  pulse PHASELOADREG after the steps.
LOCK  in  1  PLL LOCK, asynchronous to CLK.
PHASESEL  out  2  to PLL.
PHASEDIR  out  1  to PLL.
PHASESTEP  out  1  to PLL, active high.
PHASELOADREG  out  1  to PLL, active high.
BUSY  out  1  command in progress.
DONE  out  1  one-cycle pulse on command completion (success or error).
ERR  out  1  sticky lock-timeout flag.
LOCK_OK  out  1  synchronised LOCK.
PHASE_OFS  out  4*PHASE_W  signed offsets; channel k is bits [k*PHASE_W +: PHASE_W].

Behaviour:
- Reset values: all outputs 0, all accumulators 0, FSM in IDLE.
- Reset is asynchronous at assertion. Reset mid-command aborts immediately; no further pulses are emitted and the accumulators clear.
- LOCK passes through a 2-FF synchroniser. LOCK_OK is the second stage, so it lags LOCK by 2 cycles.
- CMD_READY = (state==IDLE) & LOCK_OK, driven combinationally from registers.
- A command is accepted on the CLK edge where CMD_VALID & CMD_READY. CMD_VALID while not ready is held off, not dropped.
- On accept, SEL/DIR/STEPS/LOAD are latched. PHASESEL/PHASEDIR update on that edge and stay constant until the next accept. ERR clears on that edge.
- FSM states: IDLE, SETUP, STEP_ON, STEP_OFF, LOAD_ON, LOAD_OFF, SETTLE, LOCK_WAIT.
- IDLE -> SETUP on accept.
- SETUP lasts SETUP_CYC cycles, then:
  - STEP_ON if STEPS>0;
  - else LOAD_ON if LOAD;
  - else SETTLE.
- STEP_ON: PHASESTEP=1 for PULSE_CYC cycles, then STEP_OFF.
- STEP_OFF: PHASESTEP=0 for GAP_CYC cycles.
  - The step counter and the selected accumulator update on entry to STEP_OFF, using two's-complement wrap at PHASE_W.
  - When the remaining count reaches 0, go to LOAD_ON if LOAD, else SETTLE. Otherwise return to STEP_ON.
- LOAD_ON / LOAD_OFF: PHASELOADREG=1 for PULSE_CYC cycles, then 0 for GAP_CYC cycles, then SETTLE. Accumulators are unchanged.
- SETTLE lasts SETTLE_CYC cycles, then LOCK_WAIT.
- LOCK_WAIT:
  - If LOCK_OK=1, pulse DONE and go to IDLE.
  - If LOCK_OK=0 for LOCK_TIMEOUT consecutive cycles, set ERR, pulse DONE and go to IDLE.
- Lock loss during SETUP..SETTLE does not abort the sequence; it is only evaluated in LOCK_WAIT.
- BUSY = state != IDLE.
- Cycles from accept to DONE, successful case with LOCK already high:
  SETUP_CYC + STEPS*(PULSE_CYC+GAP_CYC) + LOAD*(PULSE_CYC+GAP_CYC) + SETTLE_CYC + 1.
- PHASESTEP and PHASELOADREG are never asserted in the same cycle, and are never asserted while PHASESEL/PHASEDIR are changing.
- Accumulator wrap: +1 from 2^(PHASE_W-1)-1 gives -2^(PHASE_W-1). It wraps silently, with no flag.

Decomposition:
- Shared package pll_phase_pkg holds:
  - the state enum;
  - channel encoding constants SEL_CLKOS=0, SEL_CLKOS2=1, SEL_CLKOS3=2, SEL_CLKOP=3;
  - DIR_DELAY=0, DIR_ADVANCE=1.
- One sub-module, pll_lock_sync: 2-FF synchroniser with asynchronous active-low reset to 0. It is reusable for other PLL status inputs.
- Timers share a single down-counter sized for max(SETTLE_CYC, LOCK_TIMEOUT).

Test Plan:
- Reset with LOCK=1 -> after 2 cycles LOCK_OK=1, CMD_READY=1; all PLL outputs 0; PHASE_OFS=0.
- SEL=1, DIR=0, STEPS=3, LOAD=0, defaults -> PHASESEL=1 from accept; exactly 3 PHASESTEP pulses, each 4 cycles high / 4 low, first rising 4 cycles after accept; DONE 93 cycles after accept; offset[1]=+3.
- SEL=3, DIR=1, STEPS=0, LOAD=1 -> no PHASESTEP; one 4-cycle PHASELOADREG pulse; offset[3] unchanged.
- LOCK forced 0 after accept, STEPS=1 -> ERR=1 and DONE after SETTLE + 4096 cycles; the next accepted command clears ERR.
- Offset wrap: 2 commands of 255 delay steps on channel 0 with PHASE_W=9 -> offset[0] wraps from +255 to -2 via -256; no other channel changes.
- RST_N asserted during the 2nd pulse of a 5-step command -> PHASESTEP=0 immediately; BUSY=0; PHASE_OFS=0; after reset release a fresh command behaves normally.
